// File: rtl/ps2_digit_entry_pkg.sv
// Shared types and helpers for the PS/2 digit entry front end.
package ps2_entry_pkg;
    localparam int DIGIT_W  = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    // Caller truncates the result to its own accumulator width.
    function automatic logic [31:0] mul10_add(input logic [31:0] acc, input logic [DIGIT_W-1:0] nibble);
        return (acc << 3) + (acc << 1) + 32'(nibble);
    endfunction
endpackage

// File: rtl/ps2_digit_entry_if.sv
// Key levels, control pulses and entry/result outputs of the digit entry block.
interface ps2_digit_entry_if #(parameter int DIGITS = 4, parameter int VALUE_W = 14);
    import ps2_entry_pkg::*;

    logic [NUM_KEYS-1:0]            key_level;
    logic                           clear;
    logic                           commit;
    logic [DIGIT_W*DIGITS-1:0]      digits_bcd;
    logic [$clog2(DIGITS+1)-1:0]    digit_count;
    logic                           digit_valid;
    logic                           overflow;
    logic                           busy;
    logic [VALUE_W-1:0]             value;
    logic                           value_valid;

    modport master (
        output key_level, clear, commit,
        input  digits_bcd, digit_count, digit_valid, overflow, busy, value, value_valid
    );

    modport slave (
        input  key_level, clear, commit,
        output digits_bcd, digit_count, digit_valid, overflow, busy, value, value_valid
    );
endinterface

// File: rtl/ps2_digit_entry_key_sync_edge.sv
// Brings the PS2-domain key levels across, detects rising edges, picks the lowest key.
module key_sync_edge
    import ps2_entry_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] i_key_level,
    output logic                o_press,
    output logic [DIGIT_W-1:0]  o_press_digit
);
    logic [NUM_KEYS-1:0] r_meta;
    logic [NUM_KEYS-1:0] r_sync;
    logic [NUM_KEYS-1:0] r_prev;
    logic [NUM_KEYS-1:0] w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_key_level;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign w_edge = r_sync & ~r_prev;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        o_press       = 1'b0;
        o_press_digit = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_edge[i]) begin
                o_press       = 1'b1;
                o_press_digit = DIGIT_W'(i);
            end
        end
    end
endmodule

// File: rtl/ps2_digit_entry.sv
// Digit entry buffer with multi-cycle BCD-to-binary conversion on commit.
module ps2_digit_entry
    import ps2_entry_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int VALUE_W = 14
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    ps2_digit_entry_if.slave  bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                    r_state, w_state_nxt;
    logic [DIGIT_W*DIGITS-1:0] r_buf;
    logic [CNT_W-1:0]          r_cnt;
    logic [VALUE_W-1:0]        r_acc, r_value, w_acc_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_digit_valid, r_overflow;
    logic                      w_press;
    logic [DIGIT_W-1:0]        w_press_digit, w_nibble;
    logic                      w_append, w_ovf, w_empty, w_start, w_step;

    key_sync_edge u_sync (
        .clk          (CLOCK_50),
        .rst          (reset),
        .i_key_level  (bus.key_level),
        .o_press      (w_press),
        .o_press_digit(w_press_digit)
    );

    assign w_nibble  = r_buf[int'(r_idx)*DIGIT_W +: DIGIT_W];
    assign w_acc_nxt = VALUE_W'(mul10_add(32'(r_acc), w_nibble));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_append    = 1'b0;
        w_ovf       = 1'b0;
        w_empty     = 1'b0;
        w_start     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clear) begin
                    w_empty = 1'b1;
                end else if (bus.commit) begin
                    w_start     = 1'b1;
                    w_state_nxt = CONVERT;
                end else if (w_press) begin
                    if (r_cnt < CNT_W'(DIGITS)) w_append = 1'b1;
                    else                        w_ovf    = 1'b1;
                end
            end
            CONVERT: begin
                if (bus.clear) begin
                    w_empty     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_idx == '0) w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_empty     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_buf         <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_idx         <= '0;
            r_value       <= '0;
            r_digit_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_digit_valid <= w_append;
            r_overflow    <= w_ovf;
            if (w_empty) begin
                r_buf <= '0;
                r_cnt <= '0;
            end else if (w_append) begin
                r_buf <= {r_buf[DIGIT_W*DIGITS-DIGIT_W-1:0], w_press_digit};
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_start) begin
                r_acc <= '0;
                r_idx <= IDX_W'(DIGITS - 1);
            end else if (w_step) begin
                r_acc <= w_acc_nxt;
                r_idx <= r_idx - IDX_W'(1);
                // Final nibble lands in value as DONE is entered, so it is valid alongside value_valid.
                if (r_idx == '0) r_value <= w_acc_nxt;
            end
        end
    end

    assign bus.digits_bcd  = r_buf;
    assign bus.digit_count = r_cnt;
    assign bus.digit_valid = r_digit_valid;
    assign bus.overflow    = r_overflow;
    assign bus.busy        = (r_state == CONVERT);
    assign bus.value       = r_value;
    assign bus.value_valid = (r_state == DONE);
endmodule

// File: tb/tb_ps2_digit_entry.sv
// Scenario bench for ps2_digit_entry with expected-result queues.
module tb_ps2_digit_entry;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    logic [15:0] bcd_q[$];
    logic [13:0] val_q[$];

    ps2_digit_entry_if #(.DIGITS(4), .VALUE_W(14)) bus ();

    ps2_digit_entry #(.DIGITS(4), .VALUE_W(14)) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic key_tap(input logic [9:0] mask, input int hold,
                           output int n_dv, output int n_ov, output logic [15:0] bcd);
        n_dv = 0; n_ov = 0; bcd = '0;
        bus.key_level = mask;
        for (int i = 0; i < hold + 6; i++) begin
            if (i == hold) bus.key_level = '0;
            @(negedge clk);
            if (bus.digit_valid) begin n_dv++; bcd = bus.digits_bcd; end
            if (bus.overflow) n_ov++;
        end
    endtask

    task automatic do_commit(output int busy_n, output int lat, output logic [13:0] val);
        busy_n = 0; lat = -1; val = '0;
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.busy) busy_n++;
            if (bus.value_valid && lat < 0) begin lat = k; val = bus.value; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_commit(input string tag, input logic [13:0] exp_v);
        int bn, lat; logic [13:0] v, e;
        val_q.push_back(exp_v);
        do_commit(bn, lat, v);
        n_total++;
        if (bn !== 4) $display("FAIL %s busy_cycles got %0d want 4", tag, bn); else n_pass++;
        n_total++;
        if (lat !== 5) $display("FAIL %s value_valid_latency got %0d want 5", tag, lat); else n_pass++;
        e = val_q.pop_front();
        n_total++;
        if (v !== e) $display("FAIL %s value got %0d want %0d", tag, v, e); else n_pass++;
        n_total++;
        if (bus.digit_count !== 3'd0) $display("FAIL %s count_after got %0d want 0", tag, bus.digit_count); else n_pass++;
    endtask

    task automatic test_reset();
        n_total++;
        if ({bus.digits_bcd, bus.digit_count, bus.digit_valid, bus.overflow, bus.busy, bus.value, bus.value_valid} !== '0)
            $display("FAIL reset outputs got bcd=%h cnt=%0d busy=%b value=%0d", bus.digits_bcd, bus.digit_count, bus.busy, bus.value);
        else n_pass++;
    endtask

    task automatic test_single_hold();
        int dv, ov; logic [15:0] b;
        key_tap(10'd1 << 3, 20, dv, ov, b);
        n_total++;
        if (dv !== 1) $display("FAIL hold digit_valid_pulses got %0d want 1", dv); else n_pass++;
        n_total++;
        if (b !== 16'h0003) $display("FAIL hold bcd got %h want 0003", b); else n_pass++;
        n_total++;
        if (bus.digit_count !== 3'd1) $display("FAIL hold count got %0d want 1", bus.digit_count); else n_pass++;
        pulse_clear();
        n_total++;
        if (bus.digit_count !== 3'd0 || bus.digits_bcd !== 16'h0) $display("FAIL clear count got %0d bcd %h want 0", bus.digit_count, bus.digits_bcd);
        else n_pass++;
    endtask

    task automatic enter_digits(input string tag, input int d[]);
        int dv, ov; logic [15:0] b, e, model;
        model = '0;
        foreach (d[i]) begin
            model = {model[11:0], 4'(d[i])};
            bcd_q.push_back(model);
            key_tap(10'd1 << d[i], 6, dv, ov, b);
            e = bcd_q.pop_front();
            n_total++;
            if (dv !== 1 || b !== e) $display("FAIL %s digit%0d pulses=%0d bcd got %h want %h", tag, i, dv, b, e);
            else n_pass++;
        end
    endtask

    task automatic test_sequence();
        enter_digits("seq", '{1, 2, 3, 4});
        check_commit("seq_commit", 14'd1234);
    endtask

    task automatic test_overflow();
        int dv, ov; logic [15:0] b;
        enter_digits("ovf", '{9, 8, 7, 6});
        key_tap(10'd1 << 5, 6, dv, ov, b);
        n_total++;
        if (ov !== 1 || dv !== 0) $display("FAIL overflow pulses ov=%0d dv=%0d want 1/0", ov, dv); else n_pass++;
        n_total++;
        if (bus.digits_bcd !== 16'h9876) $display("FAIL overflow bcd got %h want 9876", bus.digits_bcd); else n_pass++;
        check_commit("ovf_commit", 14'd9876);
    endtask

    task automatic test_simultaneous();
        int dv, ov; logic [15:0] b;
        key_tap((10'd1 << 7) | (10'd1 << 2), 6, dv, ov, b);
        n_total++;
        if (dv !== 1 || b !== 16'h0002 || bus.digit_count !== 3'd1)
            $display("FAIL simultaneous pulses=%0d bcd=%h cnt=%0d want 1/0002/1", dv, b, bus.digit_count);
        else n_pass++;
        pulse_clear();
    endtask

    task automatic test_abort();
        int vv;
        enter_digits("abort", '{4, 2});
        vv = 0;
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_total++;
        if (bus.busy !== 1'b0 || bus.digit_count !== 3'd0) $display("FAIL abort busy=%b cnt=%0d want 0/0", bus.busy, bus.digit_count);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (bus.value_valid) vv++;
            @(negedge clk);
        end
        n_total++;
        if (vv !== 0) $display("FAIL abort value_valid_pulses got %0d want 0", vv); else n_pass++;
        n_total++;
        if (bus.value !== 14'd9876) $display("FAIL abort value got %0d want 9876", bus.value); else n_pass++;
    endtask

    task automatic test_reset_mid();
        enter_digits("rstmid", '{5, 5});
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.digits_bcd, bus.digit_count, bus.busy, bus.value, bus.value_valid} !== '0)
            $display("FAIL reset_mid outputs bcd=%h cnt=%0d busy=%b value=%0d want 0", bus.digits_bcd, bus.digit_count, bus.busy, bus.value);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_commit("empty_commit", 14'd0);
    endtask

    initial begin
        bus.key_level = '0;
        bus.clear     = 1'b0;
        bus.commit    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single_hold();
        test_sequence();
        test_overflow();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
